debug_ram_port_ctrl: RTL and testbench

// Synthesizable master for RV32Core's port-2 debug interfaces (CPU_Debug_InstRAM_* / CPU_Debug_DataRAM_*).

---
 rtl/debug_ram_port_ctrl.sv | 130 +++++++++++++
 tb/tb_debug_ram_port_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_ram_port_ctrl.sv
// Debug-port master for RV32Core BRAMs: streams words into inst/data RAM while
// holding the core in reset, and dumps RAM contents back out as (addr,data) pairs.
module debug_ram_port_ctrl #(
  parameter int BRAMWORDS = 4096,
  parameter int RD_LAT    = 2,
  parameter int RST_HOLD  = 8
)(
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        cmd_load,
  input  logic        cmd_dump,
  input  logic        cmd_sel,
  input  logic [12:0] cmd_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        core_rst,
  output logic [31:0] inst_a2,
  output logic [31:0] inst_wd2,
  output logic [3:0]  inst_we2,
  input  logic [31:0] inst_rd2,
  output logic [31:0] data_a2,
  output logic [31:0] data_wd2,
  output logic [3:0]  data_we2,
  input  logic [31:0] data_rd2
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REL, S_DADDR, S_DWAIT, S_DOUT} state_t;

  state_t      r_state, w_next;
  logic [12:0] r_idx, r_n, w_clamp;
  logic [7:0]  r_cnt;
  logic        r_sel, r_core_rst, r_done, r_out_valid;
  logic [31:0] r_a2, r_wd2, r_out_addr, r_out_data;
  logic [3:0]  r_we2;
  logic        w_idle, w_start_load, w_start_dump, w_zero_cmd;
  logic        w_hs_in, w_hs_out, w_last, w_rel_end, w_rd_done;
  logic [31:0] w_idx_addr, w_rd2;

  assign w_clamp      = (cmd_count > 13'(BRAMWORDS)) ? 13'(BRAMWORDS) : cmd_count;
  assign w_idle       = (r_state == S_IDLE);
  assign w_start_load = w_idle && cmd_load && (w_clamp != 13'd0);
  assign w_start_dump = w_idle && !cmd_load && cmd_dump && (w_clamp != 13'd0);
  assign w_zero_cmd   = w_idle && (cmd_load || cmd_dump) && (w_clamp == 13'd0);
  assign w_hs_in      = (r_state == S_LOAD) && in_valid;
  assign w_hs_out     = r_out_valid && out_ready;
  assign w_last       = (r_idx == r_n - 13'd1);
  assign w_rel_end    = (r_state == S_REL) && (r_cnt == 8'(RST_HOLD - 1));
  assign w_rd_done    = (r_state == S_DWAIT) && (r_cnt == 8'(RD_LAT));
  assign w_idx_addr   = {17'd0, r_idx, 2'b00};
  assign w_rd2        = r_sel ? inst_rd2 : data_rd2;

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_load) w_next = S_LOAD;
               else if (w_start_dump) w_next = S_DADDR;
      S_LOAD:  if (w_hs_in && w_last) w_next = S_REL;
      S_REL:   if (w_rel_end) w_next = S_IDLE;
      S_DADDR: w_next = S_DWAIT;
      S_DWAIT: if (w_rd_done) w_next = S_DOUT;
      S_DOUT:  if (w_hs_out) w_next = w_last ? S_IDLE : S_DADDR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      r_idx <= '0; r_n <= '0; r_cnt <= '0; r_sel <= 1'b0;
      r_core_rst <= 1'b0; r_done <= 1'b0; r_out_valid <= 1'b0;
      r_a2 <= '0; r_wd2 <= '0; r_we2 <= '0; r_out_addr <= '0; r_out_data <= '0;
    end else begin
      r_we2  <= 4'b0000;
      r_done <= w_zero_cmd;
      if (w_start_load || w_start_dump) begin
        r_sel <= cmd_sel; r_n <= w_clamp; r_idx <= '0; r_cnt <= '0;
        r_a2  <= '0; r_wd2 <= '0;
      end
      if (w_start_load) r_core_rst <= 1'b1;
      case (r_state)
        S_LOAD: if (w_hs_in) begin
          r_a2 <= w_idx_addr; r_wd2 <= in_data; r_we2 <= 4'b1111;
          r_idx <= r_idx + 13'd1;
        end
        S_REL: if (w_rel_end) begin
          r_core_rst <= 1'b0; r_done <= 1'b1;
        end else r_cnt <= r_cnt + 8'd1;
        S_DADDR: begin
          r_a2 <= w_idx_addr; r_cnt <= '0;
        end
        // rd2 is trusted only once RD_LAT full cycles have elapsed since a2 changed
        S_DWAIT: if (w_rd_done) begin
          r_out_data <= w_rd2; r_out_addr <= w_idx_addr; r_out_valid <= 1'b1;
        end else r_cnt <= r_cnt + 8'd1;
        S_DOUT: if (w_hs_out) begin
          r_out_valid <= 1'b0;
          if (w_last) r_done <= 1'b1;
          else        r_idx  <= r_idx + 13'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign busy      = !w_idle;
  assign done      = r_done;
  assign core_rst  = r_core_rst;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;

  // The unselected port is forced to zero so only one BRAM ever sees traffic
  assign inst_a2  = r_sel ? r_a2  : 32'd0;
  assign inst_wd2 = r_sel ? r_wd2 : 32'd0;
  assign inst_we2 = r_sel ? r_we2 : 4'd0;
  assign data_a2  = r_sel ? 32'd0 : r_a2;
  assign data_wd2 = r_sel ? 32'd0 : r_wd2;
  assign data_we2 = r_sel ? 4'd0  : r_we2;
endmodule

// File: tb/tb_debug_ram_port_ctrl.sv
// Directed bench for debug_ram_port_ctrl with 2-cycle BRAM read models returning ~a2.
module tb_debug_ram_port_ctrl;
  logic        CPU_CLK = 1'b0, CPU_RST_N;
  logic        cmd_load, cmd_dump, cmd_sel, in_valid, out_ready;
  logic [12:0] cmd_count;
  logic [31:0] in_data, out_addr, out_data;
  logic        in_ready, out_valid, busy, done, core_rst;
  logic [31:0] inst_a2, inst_wd2, inst_rd2, data_a2, data_wd2, data_rd2;
  logic [3:0]  inst_we2, data_we2;
  logic [31:0] ip1, dp1;
  int n_checks = 0, n_err = 0;
  int wr_inst = 0, wr_data = 0;

  debug_ram_port_ctrl dut (
    .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
    .cmd_load(cmd_load), .cmd_dump(cmd_dump), .cmd_sel(cmd_sel), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .core_rst(core_rst),
    .inst_a2(inst_a2), .inst_wd2(inst_wd2), .inst_we2(inst_we2), .inst_rd2(inst_rd2),
    .data_a2(data_a2), .data_wd2(data_wd2), .data_we2(data_we2), .data_rd2(data_rd2)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  always @(posedge CPU_CLK) begin
    ip1 <= ~inst_a2; inst_rd2 <= ip1;
    dp1 <= ~data_a2; data_rd2 <= dp1;
    if (inst_we2 != 4'd0) wr_inst <= wr_inst + 1;
    if (data_we2 != 4'd0) wr_data <= wr_data + 1;
  end

  task automatic step();
    @(posedge CPU_CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 40 && !done; k++) step();
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 30 && !out_valid; k++) step();
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic start(input logic ld, input logic dp, input logic sel, input logic [12:0] cnt);
    cmd_load = ld; cmd_dump = dp; cmd_sel = sel; cmd_count = cnt;
    step();
    cmd_load = 1'b0; cmd_dump = 1'b0;
  endtask

  initial begin
    logic [31:0] words [4];
    logic [31:0] dexp [3];
    logic [31:0] last_a2;
    int snap, nwr;
    words[0] = 32'h00000013; words[1] = 32'h00100093;
    words[2] = 32'h00200113; words[3] = 32'h00000073;
    dexp[0] = 32'hFFFFFFFF; dexp[1] = 32'hFFFFFFFB; dexp[2] = 32'hFFFFFFF7;
    CPU_RST_N = 1'b0; cmd_load = 0; cmd_dump = 0; cmd_sel = 0; cmd_count = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
    step(); step();
    chk("rst busy", 32'(busy), 0);
    chk("rst core_rst", 32'(core_rst), 0);
    chk("rst done", 32'(done), 0);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst we2", {24'd0, inst_we2, data_we2}, 0);
    CPU_RST_N = 1'b1; step();

    // load 4 words into inst RAM
    start(1, 0, 1, 13'd4);
    chk("ld core_rst", 32'(core_rst), 1);
    chk("ld in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = words[0];
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ld we2", 32'(inst_we2), 32'hF);
      chk("ld a2", inst_a2, 32'(4 * k));
      chk("ld wd2", inst_wd2, words[k]);
      chk("ld core_rst hold", 32'(core_rst), 1);
      chk("ld data port idle", data_a2 | data_wd2 | 32'(data_we2), 0);
      if (k < 3) in_data = words[k + 1];
    end
    in_valid = 1'b0;
    for (int j = 1; j < 8; j++) begin
      step();
      chk("rel core_rst", 32'(core_rst), 1);
      chk("rel done", 32'(done), 0);
      chk("rel we2", 32'(inst_we2), 0);
    end
    step();
    chk("rel end core_rst", 32'(core_rst), 0);
    chk("rel end done", 32'(done), 1);
    chk("rel end busy", 32'(busy), 0);
    step();
    chk("done pulse", 32'(done), 0);

    // dump 3 data words
    start(0, 1, 0, 13'd3);
    chk("dp busy", 32'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      wait_valid("dp valid");
      chk("dp addr", out_addr, 32'(4 * k));
      chk("dp data", out_data, dexp[k]);
      chk("dp core_rst", 32'(core_rst), 0);
      chk("dp inst idle", inst_a2, 0);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("dp done", 32'(done), (k == 2) ? 32'd1 : 32'd0);
    end
    chk("dp busy end", 32'(busy), 0);

    // dump 2 inst words with back-pressure on word 1
    start(0, 1, 1, 13'd2);
    wait_valid("bp valid0");
    chk("bp data0", out_data, 32'hFFFFFFFF);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    wait_valid("bp valid1");
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp hold valid", 32'(out_valid), 1);
      chk("bp hold addr", out_addr, 32'h4);
      chk("bp hold data", out_data, 32'hFFFFFFFB);
      chk("bp hold a2", inst_a2, 32'h4);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp done", 32'(done), 1);

    // load+dump together, then dump mid-load: only the load runs
    snap = wr_data;
    start(1, 1, 0, 13'd2);
    chk("ld+dp in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 32'hA5A5A5A5;
    step();
    chk("ld+dp we2 0", 32'(data_we2), 32'hF);
    in_valid = 1'b0; cmd_dump = 1'b1;
    step();
    cmd_dump = 1'b0;
    chk("mid dump we2", 32'(data_we2), 0);
    chk("mid dump in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 32'h5A5A5A5A;
    step();
    in_valid = 1'b0;
    chk("ld+dp a2 1", data_a2, 32'h4);
    chk("ld+dp wd2 1", data_wd2, 32'h5A5A5A5A);
    wait_done("ld+dp done");
    step();
    chk("ld+dp no dump", 32'(busy | out_valid), 0);
    chk("ld+dp writes", 32'(wr_data - snap), 2);

    // reset mid-load
    start(1, 0, 1, 13'd4);
    in_valid = 1'b1; in_data = 32'h11111111;
    step(); step();
    chk("mr we2 before", 32'(inst_we2), 32'hF);
    CPU_RST_N = 1'b0; in_valid = 1'b0;
    step();
    chk("mr we2", 32'(inst_we2), 0);
    chk("mr core_rst", 32'(core_rst), 0);
    chk("mr busy", 32'(busy), 0);
    CPU_RST_N = 1'b1; step();
    start(1, 0, 1, 13'd1);
    in_valid = 1'b1; in_data = 32'h22222222;
    step();
    in_valid = 1'b0;
    chk("mr new we2", 32'(inst_we2), 32'hF);
    chk("mr new a2", inst_a2, 0);
    wait_done("mr new done");
    step();

    // count = 0
    snap = wr_inst;
    start(1, 0, 1, 13'd0);
    chk("c0 done", 32'(done), 1);
    chk("c0 busy", 32'(busy), 0);
    chk("c0 core_rst", 32'(core_rst), 0);
    step();
    chk("c0 done clr", 32'(done), 0);
    chk("c0 writes", 32'(wr_inst - snap), 0);

    // count = 5000 clamps to 4096
    start(1, 0, 1, 13'd5000);
    in_valid = 1'b1; nwr = 0; last_a2 = 0;
    for (int k = 0; k < 4200; k++) begin
      in_data = 32'(k);
      step();
      if (inst_we2 == 4'hF) begin nwr++; last_a2 = inst_a2; end
      if (!in_ready) break;
    end
    in_valid = 1'b0;
    chk("clamp writes", 32'(nwr), 32'd4096);
    chk("clamp last a2", last_a2, 32'h00003FFC);
    wait_done("clamp done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
